// File: rtl/apple1_pia_fifo.sv
// Apple-1 keyboard/display port pair with keyboard and display FIFOs.
// Ports: sys_clock/reset, CPU bus (cpu_clken, addr, we, din, dout, cs),
//   keyboard push (kbd_data, kbd_valid), display stream
//   (dsp_data, dsp_valid, dsp_ready), keyboard interrupt irq_n.
module apple1_pia_fifo #(
  parameter logic [15:0] BASE_ADDR = 16'hD010,
  parameter int          KBD_DEPTH = 8,
  parameter int          DSP_DEPTH = 4
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic        cpu_clken,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        cs,
  input  logic [6:0]  kbd_data,
  input  logic        kbd_valid,
  output logic [6:0]  dsp_data,
  output logic        dsp_valid,
  input  logic        dsp_ready,
  output logic        irq_n
);

  localparam int KAW = $clog2(KBD_DEPTH);
  localparam int DAW = $clog2(DSP_DEPTH);
  localparam int KCW = KAW + 1;
  localparam int DCW = DAW + 1;

  logic [6:0]     kbd_mem_q [KBD_DEPTH];
  logic [6:0]     kbd_mem_d [KBD_DEPTH];
  logic [KAW-1:0] kbd_wr_q, kbd_wr_d;
  logic [KAW-1:0] kbd_rd_q, kbd_rd_d;
  logic [KCW-1:0] kbd_cnt_q, kbd_cnt_d;
  logic           kovf_q, kovf_d;
  logic           irq_en_q, irq_en_d;

  logic [6:0]     dsp_mem_q [DSP_DEPTH];
  logic [6:0]     dsp_mem_d [DSP_DEPTH];
  logic [DAW-1:0] dsp_wr_q, dsp_wr_d;
  logic [DAW-1:0] dsp_rd_q, dsp_rd_d;
  logic [DCW-1:0] dsp_cnt_q, dsp_cnt_d;
  logic           dovf_q, dovf_d;

  logic           irq_n_q, irq_n_d;

  logic       acc, rd, wr;
  logic [1:0] off;
  logic       kbd_ne, kbd_full, kbd_pop, kbd_flush, kbd_push;
  logic       kovf_set, kovf_clr;
  logic       dsp_full, dsp_pop, dsp_flush, dsp_push, dsp_req;
  logic       dovf_set, dovf_clr;
  logic       unused_ok;

  assign cs  = (addr[15:2] == BASE_ADDR[15:2]);
  assign acc = cpu_clken & cs;
  assign rd  = acc & ~we;
  assign wr  = acc & we;
  assign off = addr[1:0];

  assign unused_ok = ^{din[7:3]};

  // Keyboard FIFO control; a pop frees a slot for a same-cycle push.
  assign kbd_ne    = (kbd_cnt_q != '0);
  assign kbd_full  = (kbd_cnt_q == KCW'(KBD_DEPTH));
  assign kbd_pop   = rd & (off == 2'd0) & kbd_ne;
  assign kbd_flush = wr & (off == 2'd1) & din[0];
  assign kbd_push  = kbd_valid & ~kbd_flush & (~kbd_full | kbd_pop);
  assign kovf_set  = kbd_valid & ~kbd_flush & kbd_full & ~kbd_pop;
  assign kovf_clr  = (rd & (off == 2'd1)) |
                     (wr & (off == 2'd1) & din[2]);

  // Display FIFO control
  assign dsp_valid = (dsp_cnt_q != '0);
  assign dsp_full  = (dsp_cnt_q == DCW'(DSP_DEPTH));
  assign dsp_pop   = dsp_valid & dsp_ready;
  assign dsp_flush = wr & (off == 2'd3) & din[0];
  assign dsp_req   = wr & (off == 2'd2);
  assign dsp_push  = dsp_req & ~dsp_flush & (~dsp_full | dsp_pop);
  assign dovf_set  = dsp_req & ~dsp_flush & dsp_full & ~dsp_pop;
  assign dovf_clr  = rd & (off == 2'd3);

  assign dsp_data  = dsp_mem_q[dsp_rd_q];
  assign irq_n     = irq_n_q;

  always_comb begin
    kbd_mem_d = kbd_mem_q;
    kbd_wr_d  = kbd_wr_q;
    kbd_rd_d  = kbd_rd_q;
    kbd_cnt_d = kbd_cnt_q;
    if (kbd_flush) begin
      kbd_wr_d  = '0;
      kbd_rd_d  = '0;
      kbd_cnt_d = '0;
    end else begin
      if (kbd_push) begin
        kbd_mem_d[kbd_wr_q] = kbd_data;
        kbd_wr_d = kbd_wr_q + 1'b1;
      end
      if (kbd_pop) kbd_rd_d = kbd_rd_q + 1'b1;
      if (kbd_push & ~kbd_pop) kbd_cnt_d = kbd_cnt_q + 1'b1;
      if (kbd_pop & ~kbd_push) kbd_cnt_d = kbd_cnt_q - 1'b1;
    end
  end

  always_comb begin
    dsp_mem_d = dsp_mem_q;
    dsp_wr_d  = dsp_wr_q;
    dsp_rd_d  = dsp_rd_q;
    dsp_cnt_d = dsp_cnt_q;
    if (dsp_flush) begin
      dsp_wr_d  = '0;
      dsp_rd_d  = '0;
      dsp_cnt_d = '0;
    end else begin
      if (dsp_push) begin
        dsp_mem_d[dsp_wr_q] = din[6:0];
        dsp_wr_d = dsp_wr_q + 1'b1;
      end
      if (dsp_pop) dsp_rd_d = dsp_rd_q + 1'b1;
      if (dsp_push & ~dsp_pop) dsp_cnt_d = dsp_cnt_q + 1'b1;
      if (dsp_pop & ~dsp_push) dsp_cnt_d = dsp_cnt_q - 1'b1;
    end
  end

  // Overflow set takes priority over a same-cycle clear.
  always_comb begin
    kovf_d   = kovf_set ? 1'b1 : (kovf_clr ? 1'b0 : kovf_q);
    dovf_d   = dovf_set ? 1'b1 : (dovf_clr ? 1'b0 : dovf_q);
    irq_en_d = irq_en_q;
    if (wr & (off == 2'd1)) irq_en_d = din[1];
    irq_n_d  = ~(irq_en_q & kbd_ne);
  end

  always_comb begin
    dout = 8'h00;
    if (cs) begin
      unique case (off)
        2'd0: dout = kbd_ne ? {1'b1, kbd_mem_q[kbd_rd_q]} : 8'h00;
        2'd1: dout = {kbd_ne, kovf_q, irq_en_q, 5'b0};
        2'd2: dout = {dsp_full, 7'b0};
        2'd3: dout = {dsp_full, dovf_q, ~dsp_valid, 5'b0};
        default: dout = 8'h00;
      endcase
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < KBD_DEPTH; i++) kbd_mem_q[i] <= '0;
      for (int i = 0; i < DSP_DEPTH; i++) dsp_mem_q[i] <= '0;
      kbd_wr_q  <= '0;
      kbd_rd_q  <= '0;
      kbd_cnt_q <= '0;
      dsp_wr_q  <= '0;
      dsp_rd_q  <= '0;
      dsp_cnt_q <= '0;
      kovf_q    <= 1'b0;
      dovf_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_n_q   <= 1'b1;
    end else begin
      kbd_mem_q <= kbd_mem_d;
      dsp_mem_q <= dsp_mem_d;
      kbd_wr_q  <= kbd_wr_d;
      kbd_rd_q  <= kbd_rd_d;
      kbd_cnt_q <= kbd_cnt_d;
      dsp_wr_q  <= dsp_wr_d;
      dsp_rd_q  <= dsp_rd_d;
      dsp_cnt_q <= dsp_cnt_d;
      kovf_q    <= kovf_d;
      dovf_q    <= dovf_d;
      irq_en_q  <= irq_en_d;
      irq_n_q   <= irq_n_d;
    end
  end

endmodule

// File: tb/tb_apple1_pia_fifo.sv
// Directed bench for apple1_pia_fifo.
// Drives CPU and keyboard/display sides, checks against fixed vectors.
module tb_apple1_pia_fifo;

  logic        sys_clock = 1'b0;
  logic        reset;
  logic        cpu_clken;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        cs;
  logic [6:0]  kbd_data;
  logic        kbd_valid;
  logic [6:0]  dsp_data;
  logic        dsp_valid;
  logic        dsp_ready;
  logic        irq_n;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] BASE = 16'hD010;

  apple1_pia_fifo #(
    .BASE_ADDR(16'hD010),
    .KBD_DEPTH(8),
    .DSP_DEPTH(4)
  ) dut (
    .sys_clock(sys_clock),
    .reset(reset),
    .cpu_clken(cpu_clken),
    .addr(addr),
    .we(we),
    .din(din),
    .dout(dout),
    .cs(cs),
    .kbd_data(kbd_data),
    .kbd_valid(kbd_valid),
    .dsp_data(dsp_data),
    .dsp_valid(dsp_valid),
    .dsp_ready(dsp_ready),
    .irq_n(irq_n)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_rd(input logic [1:0] o, output logic [7:0] d);
    @(negedge sys_clock);
    addr = BASE + {14'd0, o};
    we = 1'b0;
    cpu_clken = 1'b1;
    #1 d = dout;
    @(posedge sys_clock);
    #1 cpu_clken = 1'b0;
  endtask

  task automatic cpu_wr(input logic [1:0] o, input logic [7:0] v);
    @(negedge sys_clock);
    addr = BASE + {14'd0, o};
    we = 1'b1;
    din = v;
    cpu_clken = 1'b1;
    @(posedge sys_clock);
    #1 cpu_clken = 1'b0;
    we = 1'b0;
  endtask

  task automatic kbd_push(input logic [6:0] c);
    @(negedge sys_clock);
    kbd_data = c;
    kbd_valid = 1'b1;
    @(posedge sys_clock);
    #1 kbd_valid = 1'b0;
  endtask

  // CPU pop of +0 on the same edge as a keyboard push
  task automatic rd_and_push(input logic [6:0] c, output logic [7:0] d);
    @(negedge sys_clock);
    addr = BASE;
    we = 1'b0;
    cpu_clken = 1'b1;
    kbd_data = c;
    kbd_valid = 1'b1;
    #1 d = dout;
    @(posedge sys_clock);
    #1 cpu_clken = 1'b0;
    kbd_valid = 1'b0;
  endtask

  task automatic chk_reset_regs(input string tag);
    logic [7:0] d;
    cpu_rd(2'd0, d); chk({tag, "_kbd"}, d, 8'h00);
    cpu_rd(2'd1, d); chk({tag, "_kbdcr"}, d, 8'h00);
    cpu_rd(2'd2, d); chk({tag, "_dsp"}, d, 8'h00);
    cpu_rd(2'd3, d); chk({tag, "_dspcr"}, d, 8'h20);
  endtask

  initial begin
    logic [7:0] d;
    reset = 1'b1;
    cpu_clken = 1'b0;
    addr = 16'h0000;
    we = 1'b0;
    din = 8'h00;
    kbd_data = 7'h00;
    kbd_valid = 1'b0;
    dsp_ready = 1'b0;
    repeat (3) @(posedge sys_clock);
    #1;
    chk("rst_irq_n", irq_n, 1'b1);
    chk("rst_dsp_valid", dsp_valid, 1'b0);
    chk("rst_dsp_data", dsp_data, 7'h00);
    reset = 1'b0;

    // out-of-window address
    @(negedge sys_clock);
    addr = 16'hD014;
    #1;
    chk("cs_out", cs, 1'b0);
    chk("dout_out", dout, 8'h00);
    addr = 16'hD013;
    #1 chk("cs_in", cs, 1'b1);

    chk_reset_regs("rst");

    // 1) single character
    kbd_push(7'h41);
    cpu_rd(2'd1, d); chk("t1_kbdcr", d, 8'h80);
    cpu_rd(2'd0, d); chk("t1_kbd", d, 8'hC1);
    cpu_rd(2'd0, d); chk("t1_empty", d, 8'h00);

    // 2) overflow of the keyboard FIFO
    for (int i = 0; i < 9; i++) kbd_push(7'h31 + 7'(i));
    cpu_rd(2'd1, d); chk("t2_kovf", d, 8'hC0);
    cpu_rd(2'd1, d); chk("t2_kovf_clr", d, 8'h80);
    for (int i = 0; i < 8; i++) begin
      cpu_rd(2'd0, d);
      chk("t2_pop", d, 8'hB1 + 8'(i));
    end
    cpu_rd(2'd0, d); chk("t2_drained", d, 8'h00);

    // 3) display FIFO overflow and drain
    dsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) cpu_wr(2'd2, 8'h48 + 8'(i));
    cpu_rd(2'd2, d); chk("t3_busy", d, 8'h80);
    cpu_rd(2'd3, d); chk("t3_dspcr", d, 8'hC0);
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clock);
      chk("t3_valid", dsp_valid, 1'b1);
      chk("t3_data", dsp_data, 7'h48 + 7'(i));
      dsp_ready = 1'b1;
    end
    @(negedge sys_clock);
    chk("t3_drained", dsp_valid, 1'b0);
    dsp_ready = 1'b0;
    cpu_rd(2'd3, d); chk("t3_dspcr_end", d, 8'h20);

    // 4) push and pop on the same edge with a full FIFO
    for (int i = 0; i < 8; i++) kbd_push(7'h61 + 7'(i));
    rd_and_push(7'h69, d); chk("t4_oldest", d, 8'hE1);
    cpu_rd(2'd1, d); chk("t4_no_kovf", d, 8'h80);
    for (int i = 0; i < 8; i++) begin
      cpu_rd(2'd0, d);
      chk("t4_pop", d, 8'hE2 + 8'(i));
    end
    cpu_rd(2'd0, d); chk("t4_drained", d, 8'h00);

    // 5) interrupt timing and flush
    cpu_wr(2'd1, 8'h02);
    cpu_rd(2'd1, d); chk("t5_irq_en", d, 8'h20);
    chk("t5_irq_idle", irq_n, 1'b1);
    kbd_push(7'h51);
    chk("t5_irq_lag", irq_n, 1'b1);
    @(posedge sys_clock);
    #1 chk("t5_irq_low", irq_n, 1'b0);
    cpu_rd(2'd0, d); chk("t5_kbd", d, 8'hD1);
    chk("t5_irq_hold", irq_n, 1'b0);
    @(posedge sys_clock);
    #1 chk("t5_irq_high", irq_n, 1'b1);
    for (int i = 0; i < 3; i++) kbd_push(7'h70 + 7'(i));
    cpu_wr(2'd1, 8'h01);
    cpu_rd(2'd0, d); chk("t5_flushed", d, 8'h00);
    cpu_rd(2'd1, d); chk("t5_kbdcr", d, 8'h00);

    // 6) reset while data is queued
    for (int i = 0; i < 3; i++) cpu_wr(2'd2, 8'h30 + 8'(i));
    cpu_wr(2'd1, 8'h02);
    kbd_push(7'h55);
    repeat (2) @(posedge sys_clock);
    #1;
    chk("t6_pre_valid", dsp_valid, 1'b1);
    chk("t6_pre_irq", irq_n, 1'b0);
    @(negedge sys_clock);
    reset = 1'b1;
    #1;
    chk("t6_valid", dsp_valid, 1'b0);
    chk("t6_irq_n", irq_n, 1'b1);
    chk("t6_data", dsp_data, 7'h00);
    @(posedge sys_clock);
    #1 reset = 1'b0;
    chk_reset_regs("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
